seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader_if.sv | 31 +++
 rtl/seg7_reader.sv | 148 ++++++++++++++
 tb/tb_seg7_reader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_reader_if.sv
// Result handshake between the seven-segment reader and its consumer.
// The master side (reader) presents a decoded digit and holds it until the consumer accepts it.
interface seg7_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] digit;
    logic       dp;
    logic       blank;
    logic       invalid;
    logic [7:0] change_count;

    modport master (
        output out_valid,
        output digit,
        output dp,
        output blank,
        output invalid,
        output change_count,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  digit,
        input  dp,
        input  blank,
        input  invalid,
        input  change_count,
        output out_ready
    );
endinterface

// File: rtl/seg7_reader.sv
// Debounces an active-low 7-segment pattern and reports each new stable pattern as a hex digit.
// Report appears STABLE_CYCLES+1 edges after a new pattern is sampled; it is held until accepted.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] seg_in,
    seg7_reader_if.master bus
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    typedef enum logic {
        WATCH = 1'b0,
        PEND  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] seg_q;
    logic [7:0] cand;
    logic [7:0] cnt;
    logic [7:0] last_seg;
    logic [7:0] held;
    logic       stable;

    logic       capture;
    logic       accept;

    logic [3:0] dec_digit;
    logic       dec_blank;
    logic       dec_invalid;

    logic [3:0] digit_r;
    logic       dp_r;
    logic       blank_r;
    logic       invalid_r;
    logic [7:0] change_count_r;

    // Input register plus stability tracker; runs regardless of FSM state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_q <= 8'hFF;
            cand  <= 8'hFF;
            cnt   <= 8'd0;
        end else begin
            seg_q <= seg_in;
            if (seg_q != cand) begin
                cand <= seg_q;
                cnt  <= 8'd1;
            end else if (cnt != STABLE_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign stable = (cnt == STABLE_MAX);

    always_comb begin
        dec_digit   = 4'h0;
        dec_blank   = 1'b0;
        dec_invalid = 1'b0;
        case (cand[6:0])
            7'h40:   dec_digit = 4'h0;
            7'h79:   dec_digit = 4'h1;
            7'h24:   dec_digit = 4'h2;
            7'h30:   dec_digit = 4'h3;
            7'h19:   dec_digit = 4'h4;
            7'h12:   dec_digit = 4'h5;
            7'h02:   dec_digit = 4'h6;
            7'h78:   dec_digit = 4'h7;
            7'h00:   dec_digit = 4'h8;
            7'h10:   dec_digit = 4'h9;
            7'h08:   dec_digit = 4'hA;
            7'h03:   dec_digit = 4'hB;
            7'h46:   dec_digit = 4'hC;
            7'h21:   dec_digit = 4'hD;
            7'h06:   dec_digit = 4'hE;
            7'h0E:   dec_digit = 4'hF;
            7'h7F:   dec_blank = 1'b1;
            default: dec_invalid = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= WATCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            WATCH: begin
                // Re-reporting the last accepted pattern is suppressed here.
                if (stable && (cand != last_seg)) begin
                    state_nxt = PEND;
                    capture   = 1'b1;
                end
            end
            PEND: begin
                if (bus.out_ready) begin
                    state_nxt = WATCH;
                    accept    = 1'b1;
                end
            end
            default: state_nxt = WATCH;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            digit_r        <= 4'h0;
            dp_r           <= 1'b0;
            blank_r        <= 1'b0;
            invalid_r      <= 1'b0;
            held           <= 8'hFF;
            last_seg       <= 8'hFF;
            change_count_r <= 8'd0;
        end else begin
            if (capture) begin
                digit_r   <= dec_digit;
                dp_r      <= ~cand[7];
                blank_r   <= dec_blank;
                invalid_r <= dec_invalid;
                held      <= cand;
            end
            if (accept) begin
                last_seg       <= held;
                change_count_r <= change_count_r + 8'd1;
            end
        end
    end

    assign bus.out_valid    = (state == PEND);
    assign bus.digit        = digit_r;
    assign bus.dp           = dp_r;
    assign bus.blank        = blank_r;
    assign bus.invalid      = invalid_r;
    assign bus.change_count = change_count_r;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: table-driven decode vectors, hand-written corner sequences and a
// randomized phase, all checked every cycle against a queue-based reference model.
module tb_seg7_reader;

    localparam int S = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [7:0] seg_in   = 8'hFF;

    seg7_reader_if bus ();

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .seg_in   (seg_in),
        .bus      (bus.master)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] digit;
        logic       dp;
        logic       blank;
        logic       invalid;
    } vec_t;

    vec_t vecs[22];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [7:0] m_sq;
    logic [7:0] m_hist[$];
    logic [7:0] m_last;
    logic [7:0] m_held;
    logic       m_pend;
    logic [7:0] m_cnt;
    logic [3:0] m_digit;
    logic       m_dp, m_blank, m_invalid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] s, input logic [3:0] d, input logic p,
                                input logic b, input logic i);
        vec_t v;
        v.seg = s; v.digit = d; v.dp = p; v.blank = b; v.invalid = i;
        return v;
    endfunction

    task automatic model_reset();
        m_sq = 8'hFF;
        m_hist.delete();
        m_last = 8'hFF;
        m_held = 8'hFF;
        m_pend = 1'b0;
        m_cnt = 8'd0;
        m_digit = 4'h0; m_dp = 1'b0; m_blank = 1'b0; m_invalid = 1'b0;
    endtask

    task automatic model_decode(input logic [7:0] p);
        m_digit = 4'h0; m_blank = 1'b0; m_invalid = 1'b1;
        m_dp = ~p[7];
        if (p[6:0] == 7'h7F) begin
            m_blank = 1'b1; m_invalid = 1'b0;
        end
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p[6:0]) begin
                m_digit = 4'(i); m_invalid = 1'b0;
            end
    endtask

    // One rising edge: a pattern counts as stable once the last S samples agree.
    task automatic model_edge();
        int run;
        logic [7:0] c;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        run = 0;
        c = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : 8'hFF;
        for (int i = m_hist.size() - 1; i >= 0 && run < S; i--) begin
            if (m_hist[i] != c) break;
            run++;
        end
        if (m_pend) begin
            if (bus.out_ready) begin
                m_pend = 1'b0;
                m_last = m_held;
                m_cnt  = m_cnt + 8'd1;
            end
        end else if (run >= S && c != m_last) begin
            m_pend = 1'b1;
            m_held = c;
            model_decode(c);
        end
        m_hist.push_back(m_sq);
        if (m_hist.size() > 64) void'(m_hist.pop_front());
        m_sq = seg_in;
    endtask

    task automatic model_compare();
        chk("mdl_valid", 32'(bus.out_valid), 32'(m_pend));
        chk("mdl_count", 32'(bus.change_count), 32'(m_cnt));
        if (m_pend) begin
            chk("mdl_digit", 32'(bus.digit), 32'(m_digit));
            chk("mdl_dp", 32'(bus.dp), 32'(m_dp));
            chk("mdl_blank", 32'(bus.blank), 32'(m_blank));
            chk("mdl_invalid", 32'(bus.invalid), 32'(m_invalid));
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        model_compare();
    endtask

    task automatic wait_valid(input int lim, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (bus.out_valid) ok = 1'b1;
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        model_reset();
        repeat (3) tick();
        RESET_N = 1'b1;
    endtask

    // Pattern already on seg_in; edge 0 is the next rising edge.
    task automatic check_latency(input string tag);
        for (int e = 0; e <= S + 1; e++) begin
            tick();
            chk({tag, "_valid_edge"}, 32'(bus.out_valid), (e == S + 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int seen;
        int hold;
        vecs[0]  = mk(8'hF9, 4'h1, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(8'hA4, 4'h2, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(8'hB0, 4'h3, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(8'h99, 4'h4, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(8'h92, 4'h5, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(8'h82, 4'h6, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(8'hF8, 4'h7, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(8'h80, 4'h8, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(8'h90, 4'h9, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(8'h88, 4'hA, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(8'h83, 4'hB, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(8'hC6, 4'hC, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(8'hA1, 4'hD, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(8'h86, 4'hE, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(8'h8E, 4'hF, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(8'h0E, 4'hF, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(8'h7F, 4'h0, 1'b1, 1'b1, 1'b0);
        vecs[17] = mk(8'hFF, 4'h0, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(8'h55, 4'h0, 1'b1, 1'b0, 1'b1);
        vecs[19] = mk(8'hD5, 4'h0, 1'b0, 1'b0, 1'b1);
        vecs[20] = mk(8'h40, 4'h0, 1'b1, 1'b0, 1'b0);
        vecs[21] = mk(8'hC0, 4'h0, 1'b0, 1'b0, 1'b0);

        bus.out_ready = 1'b0;
        seg_in = 8'hFF;
        model_reset();
        repeat (3) tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_digit", 32'(bus.digit), 32'd0);
        chk("rst_dp", 32'(bus.dp), 32'd0);
        chk("rst_blank", 32'(bus.blank), 32'd0);
        chk("rst_invalid", 32'(bus.invalid), 32'd0);
        chk("rst_count", 32'(bus.change_count), 32'd0);
        RESET_N = 1'b1;

        // Blank display after reset is not news; nor is a 3-sample glitch.
        seen = 0;
        repeat (12) begin tick(); if (bus.out_valid) seen++; end
        chk("blank_after_reset", 32'(seen), 32'd0);
        seg_in = 8'h92;
        repeat (3) begin tick(); if (bus.out_valid) seen++; end
        seg_in = 8'hFF;
        repeat (15) begin tick(); if (bus.out_valid) seen++; end
        chk("glitch_valid", 32'(seen), 32'd0);
        chk("glitch_count", 32'(bus.change_count), 32'd0);

        seg_in = 8'hC0;
        check_latency("lat");
        chk("lat_digit", 32'(bus.digit), 32'd0);
        chk("lat_dp", 32'(bus.dp), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("lat_count", 32'(bus.change_count), 32'd1);
        chk("lat_drop", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 22; i++) begin
            seg_in = vecs[i].seg;
            wait_valid(3 * S + 4, "vec_timeout");
            chk("vec_digit", 32'(bus.digit), 32'(vecs[i].digit));
            chk("vec_dp", 32'(bus.dp), 32'(vecs[i].dp));
            chk("vec_blank", 32'(bus.blank), 32'(vecs[i].blank));
            chk("vec_invalid", 32'(bus.invalid), 32'(vecs[i].invalid));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end

        // Held result survives input activity; new pattern follows after acceptance.
        seg_in = 8'h79;
        wait_valid(3 * S + 4, "hold_timeout");
        seg_in = 8'h24;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_digit", 32'(bus.digit), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("spacing", 32'(bus.out_valid), 32'd0);
        wait_valid(3 * S + 4, "second_timeout");
        chk("second_digit", 32'(bus.digit), 32'd2);
        chk("second_dp", 32'(bus.dp), 32'd1);
        tick();
        bus.out_ready = 1'b0;

        // Excursion during PEND that returns to the held pattern is not reported twice.
        seg_in = 8'hF9;
        wait_valid(3 * S + 4, "ret_timeout");
        seg_in = 8'hA4;
        repeat (8) tick();
        seg_in = 8'hF9;
        repeat (8) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        seen = 0;
        repeat (20) begin tick(); if (bus.out_valid) seen++; end
        chk("no_rereport", 32'(seen), 32'd0);

        // Asynchronous reset while a result is pending.
        seg_in = 8'hC0;
        wait_valid(3 * S + 4, "arst_timeout");
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_digit", 32'(bus.digit), 32'd0);
        chk("arst_dp", 32'(bus.dp), 32'd0);
        chk("arst_blank", 32'(bus.blank), 32'd0);
        chk("arst_invalid", 32'(bus.invalid), 32'd0);
        chk("arst_count", 32'(bus.change_count), 32'd0);
        repeat (2) tick();
        RESET_N = 1'b1;
        check_latency("post_rst");
        chk("post_rst_digit", 32'(bus.digit), 32'd0);

        // 256 accepted reports wrap the counter.
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            seg_in = (k % 2 == 0) ? 8'hC0 : 8'hF9;
            wait_valid(3 * S + 4, "wrap_timeout");
            tick();
            if (k == 254) chk("wrap_255", 32'(bus.change_count), 32'd255);
        end
        chk("wrap_zero", 32'(bus.change_count), 32'd0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0)
                seg_in = vecs[$urandom_range(0, 21)].seg ^ {1'($urandom_range(0, 1)), 7'h00};
            else
                seg_in = 8'($urandom);
            hold = $urandom_range(1, 2 * S + 2);
            for (int h = 0; h < hold; h++) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
